multi_bar_sq: RTL

Parametrised successor to the single divided colour square. It draws a rectangle split into CHANNELS horizontal stripes, each with its own divide point, so one block can show several level bars (e.g. multi-trace amplitude). Divide values arrive over a valid/ready handshake and are double-buffered so they only change at frame start, which prevents tearing. It sits in the pixel pipeline between the VGA timing generator and the colour mixer, with fixed 2-cycle latency.

---
 rtl/multi_bar_sq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/multi_bar_sq.sv
// multi_bar_sq: rectangle split into CHANNELS horizontal stripes, each stripe
// a two-colour level bar with its own divide point. Divide sets arrive on a
// valid/ready handshake, sit in a shadow register and are applied only at
// frame start so a frame never shows two different sets.
// Optional feature macro: MULTI_BAR_SQ_SLEW_EN -- the shadow loads a target
// and each active divide walks toward it by at most STEP per frame start.
// Pixel path latency is fixed at 2 clocks.
module multi_bar_sq #(
    parameter int          X_OFF    = 0,
    parameter int          Y_OFF    = 0,
    parameter int          W        = 100,
    parameter int          H        = 100,
    parameter int          CHANNELS = 4,
    parameter logic [5:0]  COLOR1   = 6'b000000,
    parameter logic [5:0]  COLOR2   = 6'b111111,
    parameter int          STEP     = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [9:0]              x_px,
    input  logic [9:0]              y_px,
    input  logic [10*CHANNELS-1:0]  div_in,
    input  logic                    div_valid,
    output logic                    div_ready,
    output logic [5:0]              color_px,
    output logic                    frame_tick
);

    localparam int          SH   = H / CHANNELS;
    localparam int          CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [11:0] X_LO = 12'(X_OFF);
    localparam logic [11:0] X_HI = 12'(X_OFF + W);
    localparam logic [11:0] Y_LO = 12'(Y_OFF);
    localparam logic [11:0] Y_HI = 12'(Y_OFF + H);

    logic          w_inside;
    logic [CW-1:0] w_ch;
    logic          w_origin;
    logic          w_accept;
    logic          w_xfer;

    logic          r_inside;
    logic [9:0]    r_x_rel;
    logic [CW-1:0] r_ch;
    logic [5:0]    r_color;
    logic          r_origin_prev;
    logic          r_fs;
    logic          r_pend;
    logic [10*CHANNELS-1:0] r_shadow;
    logic [9:0]    r_active [CHANNELS];

    assign w_inside = ({2'b00, x_px} > X_LO) && ({2'b00, x_px} <= X_HI) &&
                      ({2'b00, y_px} > Y_LO) && ({2'b00, y_px} <= Y_HI);
    assign w_origin = (x_px == 10'd0) && (y_px == 10'd0);
    assign w_accept = div_valid && !r_pend;
    assign w_xfer   = r_fs && r_pend;

    assign div_ready  = !r_pend;
    assign frame_tick = w_xfer;
    assign color_px   = r_color;

    // Stripe index: count the stripe boundaries the current row lies below.
    always_comb begin
        w_ch = '0;
        for (int c = 1; c < CHANNELS; c++) begin
            if ({2'b00, y_px} > 12'(Y_OFF + c * SH))
                w_ch = CW'(c);
        end
    end

    // Two-stage pixel pipeline: geometry, then colour select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inside <= 1'b0;
            r_x_rel  <= '0;
            r_ch     <= '0;
            r_color  <= '0;
        end else begin
            r_inside <= w_inside;
            r_x_rel  <= x_px - 10'(X_OFF);
            r_ch     <= w_ch;
            if (!r_inside)
                r_color <= '0;
            else if (r_x_rel > r_active[r_ch])
                r_color <= COLOR1;
            else
                r_color <= COLOR2;
        end
    end

    // Frame start: registered rising edge of the (0,0) coordinate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_origin_prev <= 1'b0;
            r_fs          <= 1'b0;
        end else begin
            r_origin_prev <= w_origin;
            r_fs          <= w_origin && !r_origin_prev;
        end
    end

    // Handshake: one pending set at a time, released by the frame-start transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend   <= 1'b0;
            r_shadow <= '0;
        end else begin
            if (w_xfer)
                r_pend <= 1'b0;
            else if (w_accept)
                r_pend <= 1'b1;
            if (w_accept)
                r_shadow <= div_in;
        end
    end

`ifdef MULTI_BAR_SQ_SLEW_EN
    logic [9:0] r_target [CHANNELS];

    // Move one step toward the target without overshooting it.
    function automatic logic [9:0] slew_step(input logic [9:0] cur, input logic [9:0] tgt);
        logic [9:0] diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return (diff > 10'(STEP)) ? cur + 10'(STEP) : tgt;
        end else begin
            diff = cur - tgt;
            return (diff > 10'(STEP)) ? cur - 10'(STEP) : tgt;
        end
    endfunction

    // Target takes the shadow on transfer; active slews on every frame start
    // toward the target value held before that edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_target[c] <= '0;
                r_active[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_xfer)
                    r_target[c] <= r_shadow[c*10 +: 10];
                if (r_fs)
                    r_active[c] <= slew_step(r_active[c], r_target[c]);
            end
        end
    end
`else
    // Active divides take the shadow directly on transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++)
                r_active[c] <= '0;
        end else if (w_xfer) begin
            for (int c = 0; c < CHANNELS; c++)
                r_active[c] <= r_shadow[c*10 +: 10];
        end
    end
`endif

endmodule
